// File: rtl/fpu_dot_sequencer_if.sv
// Handshake, operand-memory and FPU signals of the dot-product sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface fpu_dot_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [LEN_W-1:0]  length;
    logic [31:0]       acc_init;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_a_addr;
    logic [ADDR_W-1:0] mem_b_addr;
    logic [31:0]       mem_a_data;
    logic [31:0]       mem_b_data;
    logic [2:0]        fpu_op;
    logic [31:0]       fpu_a;
    logic [31:0]       fpu_b;
    logic [31:0]       fpu_c;
    logic [31:0]       fpu_result;
    logic              fpu_valid;
    logic              busy;
    logic              done;
    logic [31:0]       dot_result;
    logic [LEN_W-1:0]  elem_count;

    modport master (
        output start, abort, base_a, base_b, length, acc_init,
               mem_a_data, mem_b_data, fpu_result, fpu_valid,
        input  mem_rd_en, mem_a_addr, mem_b_addr, fpu_op, fpu_a, fpu_b, fpu_c,
               busy, done, dot_result, elem_count
    );

    modport slave (
        input  start, abort, base_a, base_b, length, acc_init,
               mem_a_data, mem_b_data, fpu_result, fpu_valid,
        output mem_rd_en, mem_a_addr, mem_b_addr, fpu_op, fpu_a, fpu_b, fpu_c,
               busy, done, dot_result, elem_count
    );
endinterface

// File: rtl/fpu_dot_sequencer.sv
// Dot-product sequencer: walks two operand memories, issues MAC ops to the shared
// one-cycle FPU and chains each FPU result into the accumulator of the next element.
module fpu_dot_sequencer #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    fpu_dot_sequencer_if.slave bus
);
    localparam logic [2:0] OP_MAC = 3'b111;
    localparam logic [2:0] OP_NOP = 3'b000;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_FPU, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [LEN_W-1:0]  length_q, length_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [31:0]       dot_q, dot_d;
    logic [LEN_W-1:0]  idx_inc;
    logic              abortable;

    assign idx_inc   = idx_q + LEN_W'(1);
    assign abortable = (state_q != IDLE) && (state_q != DONE);

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path can infer a latch.
        state_d  = state_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        length_d = length_q;
        idx_d    = idx_q;
        count_d  = count_q;
        acc_d    = acc_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        dot_d    = dot_q;

        if (bus.abort && abortable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.length != '0) begin
                            base_a_d = bus.base_a;
                            base_b_d = bus.base_b;
                            length_d = bus.length;
                            acc_d    = bus.acc_init;
                            idx_d    = '0;
                            count_d  = '0;
                            state_d  = FETCH;
                        end else begin
                            dot_d   = bus.acc_init;
                            state_d = DONE;
                        end
                    end
                end
                FETCH:    state_d = WAIT_MEM;
                WAIT_MEM: begin
                    op_a_d  = bus.mem_a_data;
                    op_b_d  = bus.mem_b_data;
                    state_d = ISSUE;
                end
                ISSUE:    state_d = WAIT_FPU;
                // Without fpu_valid the MAC is still in flight; operands stay on the bus.
                WAIT_FPU: begin
                    if (bus.fpu_valid) begin
                        acc_d   = bus.fpu_result;
                        idx_d   = idx_inc;
                        count_d = idx_inc;
                        if (idx_inc == length_q) begin
                            dot_d   = bus.fpu_result;
                            state_d = DONE;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // NOTE: registers take non-blocking assignments so every one updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_a_q <= '0;
            base_b_q <= '0;
            length_q <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            dot_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            length_q <= length_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            dot_q    <= dot_d;
        end
    end

    assign bus.mem_rd_en  = (state_q == FETCH);
    assign bus.mem_a_addr = base_a_q + ADDR_W'(idx_q);
    assign bus.mem_b_addr = base_b_q + ADDR_W'(idx_q);
    assign bus.fpu_op     = (state_q == ISSUE || state_q == WAIT_FPU) ? OP_MAC : OP_NOP;
    assign bus.fpu_a      = op_a_q;
    assign bus.fpu_b      = op_b_q;
    assign bus.fpu_c      = acc_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.dot_result = dot_q;
    assign bus.elem_count = count_q;
endmodule

// File: tb/tb_fpu_dot_sequencer.sv
// Bench for fpu_dot_sequencer: operand memories plus a one-cycle MAC FPU model, and a
// cycle-timeline reference built from element count, stalls and plain real arithmetic.
module tb_fpu_dot_sequencer;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 8;
    localparam int MAXC   = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_dot_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();

    fpu_dot_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    int          va[$];
    int          vb[$];
    int          stall_elem = -1;
    int          stall_len  = 0;
    int          stalled    = 0;
    int          n_vec      = 0;
    int          n_err      = 0;
    logic [31:0] last_dot   = 32'h0;

    function automatic real from_sp(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:0] == 31'h0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] to_sp(input real r);
        logic s;
        int   e;
        real  m;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    // Synchronous-read operand memories; data is junk except the cycle after a read.
    always @(posedge clk) begin
        bus.mem_a_data <= bus.mem_rd_en ? mem_a[bus.mem_a_addr] : $urandom;
        bus.mem_b_data <= bus.mem_rd_en ? mem_b[bus.mem_b_addr] : $urandom;
    end

    // Registered MAC FPU; optionally withholds fpu_valid on one chosen element.
    always @(posedge clk) begin
        if (rst) begin
            bus.fpu_valid  <= 1'b0;
            bus.fpu_result <= 32'h0;
            stalled        <= 0;
        end else if (bus.fpu_op == 3'b111 && !bus.fpu_valid) begin
            if (int'(bus.elem_count) == stall_elem && stalled < stall_len) begin
                bus.fpu_valid  <= 1'b0;
                bus.fpu_result <= $urandom;
                stalled        <= stalled + 1;
            end else begin
                bus.fpu_valid  <= 1'b1;
                bus.fpu_result <= to_sp(from_sp(bus.fpu_a) * from_sp(bus.fpu_b) + from_sp(bus.fpu_c));
            end
        end else begin
            bus.fpu_valid  <= 1'b0;
            bus.fpu_result <= $urandom;
            if (bus.fpu_op != 3'b111) stalled <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation from the start pulse: expected {busy,done,rd_en,fpu_op} per cycle,
    // operand/address expectations, final result. abort_c/restart_c/rst_c of 0 mean unused.
    task automatic run_op(input int len, input logic [7:0] ba, input logic [7:0] bb,
                          input logic [31:0] acc0, input int s_elem, input int s_len,
                          input int abort_c, input int restart_c, input int rst_c);
        logic [5:0]  sched [MAXC];
        logic [31:0] ea [MAXC];
        logic [31:0] eb [MAXC];
        logic [31:0] ec [MAXC];
        logic [15:0] eaddr [MAXC];
        logic [31:0] exp_dot;
        real         acc;
        int          c;
        int          done_c;
        int          stop_c;

        for (int i = 0; i < MAXC; i++) begin
            sched[i] = 6'b0; ea[i] = 32'h0; eb[i] = 32'h0; ec[i] = 32'h0; eaddr[i] = 16'h0;
        end
        acc = from_sp(acc0);
        c   = 1;
        for (int i = 0; i < len; i++) begin
            int st = (i == s_elem) ? s_len : 0;
            mem_a[8'(ba + 8'(i))] = to_sp(real'(va[i]));
            mem_b[8'(bb + 8'(i))] = to_sp(real'(vb[i]));
            sched[c]     = 6'b101000;
            eaddr[c]     = {ba + 8'(i), bb + 8'(i)};
            sched[c + 1] = 6'b100000;
            for (int k = 0; k < 2 + st; k++) begin
                sched[c + 2 + k] = 6'b100111;
                ea[c + 2 + k]    = to_sp(real'(va[i]));
                eb[c + 2 + k]    = to_sp(real'(vb[i]));
                ec[c + 2 + k]    = (i == 0) ? acc0 : to_sp(acc);
            end
            acc = acc + real'(va[i] * vb[i]);
            c   = c + 4 + st;
        end
        done_c        = c;
        sched[done_c] = 6'b110000;
        exp_dot       = (len == 0) ? acc0 : to_sp(acc);
        stop_c        = done_c + 2;
        if (abort_c > 0) begin
            for (int i = abort_c + 1; i < MAXC; i++) sched[i] = 6'b0;
            exp_dot = last_dot;
            stop_c  = abort_c + 3;
        end
        if (rst_c > 0) begin
            for (int i = rst_c + 1; i < MAXC; i++) sched[i] = 6'b0;
            exp_dot = 32'h0;
            stop_c  = rst_c + 3;
        end

        @(negedge clk);
        stall_elem   = s_elem;
        stall_len    = s_len;
        bus.base_a   = ba;
        bus.base_b   = bb;
        bus.length   = 8'(len);
        bus.acc_init = acc0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= stop_c; cyc++) begin
            check($sformatf("ctrl c%0d", cyc),
                  {26'b0, bus.busy, bus.done, bus.mem_rd_en, bus.fpu_op}, {26'b0, sched[cyc]});
            if (sched[cyc][3])
                check($sformatf("addr c%0d", cyc), {16'h0, bus.mem_a_addr, bus.mem_b_addr}, {16'h0, eaddr[cyc]});
            if (sched[cyc][2:0] == 3'b111) begin
                check($sformatf("fpu_a c%0d", cyc), bus.fpu_a, ea[cyc]);
                check($sformatf("fpu_b c%0d", cyc), bus.fpu_b, eb[cyc]);
                check($sformatf("fpu_c c%0d", cyc), bus.fpu_c, ec[cyc]);
            end
            if (abort_c == 0 && rst_c == 0 && cyc == done_c + 1) begin
                check("dot_result", bus.dot_result, exp_dot);
                if (len > 0) check("elem_count", {24'h0, bus.elem_count}, 32'(len));
            end
            if (abort_c > 0 && cyc == abort_c + 1)
                check("abort dot_result", bus.dot_result, exp_dot);
            if (rst_c > 0 && cyc == rst_c + 1) begin
                check("rst dot_result", bus.dot_result, 32'h0);
                check("rst elem_count", {24'h0, bus.elem_count}, 32'h0);
                check("rst fpu_abc", bus.fpu_a | bus.fpu_b | bus.fpu_c, 32'h0);
                check("rst addr", {16'h0, bus.mem_a_addr, bus.mem_b_addr}, 32'h0);
            end
            bus.abort = (cyc == abort_c);
            rst       = (cyc == rst_c);
            bus.start  = (cyc == restart_c);
            bus.base_a = (cyc == restart_c) ? ba ^ 8'h55 : ba;
            @(negedge clk);
        end
        last_dot   = exp_dot;
        stall_elem = -1;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.base_a = '0; bus.base_b = '0; bus.length = '0; bus.acc_init = 32'h0;
        for (int i = 0; i < 256; i++) begin mem_a[i] = 32'h0; mem_b[i] = 32'h0; end
        repeat (3) @(negedge clk);
        check("reset ctrl", {26'b0, bus.busy, bus.done, bus.mem_rd_en, bus.fpu_op}, 32'h0);
        check("reset dot", bus.dot_result, 32'h0);
        check("reset misc", {bus.mem_a_addr, bus.mem_b_addr, bus.elem_count, 8'h0} | bus.fpu_a | bus.fpu_c, 32'h0);
        rst = 1'b0;

        // Basic dot product, 1 + 1*4 + 2*5 + 3*6 = 33.0
        va = {1, 2, 3}; vb = {4, 5, 6};
        run_op(3, 8'h00, 8'h40, 32'h3F800000, -1, 0, 0, 0, 0);
        check("basic dot", bus.dot_result, 32'h42040000);
        // Zero length passes acc_init straight through
        run_op(0, 8'h00, 8'h40, 32'h40490FDB, -1, 0, 0, 0, 0);
        check("zero-len dot", bus.dot_result, 32'h40490FDB);
        // Address wrap
        va = {1, 2, 3, 4}; vb = {5, 6, 7, 8};
        run_op(4, 8'hFE, 8'h10, 32'h0, -1, 0, 0, 0, 0);
        // FPU stall of 3 cycles on element 2
        va = {1, 2, 3}; vb = {4, 5, 6};
        run_op(3, 8'h00, 8'h40, 32'h3F800000, 1, 3, 0, 0, 0);
        check("stall dot", bus.dot_result, 32'h42040000);
        // Abort in WAIT_FPU of element 2, then a clean rerun
        run_op(3, 8'h20, 8'h60, 32'h40000000, -1, 0, 8, 0, 0);
        check("after abort dot", bus.dot_result, 32'h42040000);
        run_op(3, 8'h00, 8'h40, 32'h3F800000, -1, 0, 0, 0, 0);
        // start while busy, then reset mid-operation
        run_op(3, 8'h30, 8'h70, 32'h3F800000, -1, 0, 0, 5, 0);
        run_op(3, 8'h30, 8'h70, 32'h3F800000, -1, 0, 0, 0, 7);

        for (int t = 0; t < 30; t++) begin
            int len = $urandom_range(0, 6);
            int ab  = 0;
            va.delete(); vb.delete();
            for (int i = 0; i < len; i++) begin
                va.push_back($urandom_range(0, 15));
                vb.push_back($urandom_range(0, 15));
            end
            if (len > 0 && $urandom_range(0, 4) == 0) ab = $urandom_range(1, 4 * len);
            run_op(len, 8'($urandom), 8'($urandom), to_sp(real'($urandom_range(0, 100))),
                   $urandom_range(0, 5), $urandom_range(0, 3), ab, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
